// File: rtl/udma_cpi_pixel_packer.sv
// udma_cpi_pixel_packer
// CPI capture path for samples already in the peripheral clock domain.
// A frame FSM handles frame decimation and an optional crop window.
// Accepted 8- or 16-bit pixels are packed LSB-lane-first into OUT_WIDTH words.
// Packed words queue in a small show-ahead FIFO ahead of the uDMA RX port.
module udma_cpi_pixel_packer #(
  parameter int DATA_WIDTH = 10,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_mode_i,
  input  logic [3:0]            cfg_frame_skip_i,
  input  logic                  cfg_win_en_i,
  input  logic [CNT_WIDTH-1:0]  cfg_x_start_i,
  input  logic [CNT_WIDTH-1:0]  cfg_x_end_i,
  input  logic [CNT_WIDTH-1:0]  cfg_y_start_i,
  input  logic [CNT_WIDTH-1:0]  cfg_y_end_i,
  input  logic                  cfg_clr_i,
  input  logic                  pix_valid_i,
  input  logic [DATA_WIDTH-1:0] pix_data_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_evt_o,
  output logic                  overflow_o,
  output logic                  busy_o
);

  localparam int LANES8  = OUT_WIDTH / 8;
  localparam int LANES16 = OUT_WIDTH / 16;
  localparam int LANE_W  = $clog2(LANES8);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_SKIP     = 3'd3,
    ST_FLUSH    = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // sync edge detection
  logic vsync_q;
  logic hsync_q;
  logic sof;
  logic eof;
  logic eol;

  logic [3:0] skip_cnt;

  // coordinates and per-frame configuration snapshot
  logic [CNT_WIDTH-1:0] x_cnt;
  logic [CNT_WIDTH-1:0] y_cnt;
  logic                 mode_q;
  logic                 win_en_q;
  logic [CNT_WIDTH-1:0] x_start_q;
  logic [CNT_WIDTH-1:0] x_end_q;
  logic [CNT_WIDTH-1:0] y_start_q;
  logic [CNT_WIDTH-1:0] y_end_q;

  // packing
  logic [7:0]           pix8;
  logic [15:0]          pix16;
  logic                 in_win;
  logic                 accept;
  logic [LANE_W-1:0]    lane;
  logic [LANE_W-1:0]    last_lane;
  logic [OUT_WIDTH-1:0] pack;
  logic [OUT_WIDTH-1:0] pack8_nxt;
  logic [OUT_WIDTH-1:0] pack16_nxt;
  logic [OUT_WIDTH-1:0] pack_nxt;
  logic                 push_req;
  logic [OUT_WIDTH-1:0] push_word;

  // output FIFO
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push_ok;
  logic                 overflow;

  assign sof = vsync_i & ~vsync_q;
  assign eof = ~vsync_i & vsync_q;
  assign eol = ~hsync_i & hsync_q;

  assign pix8  = pix_data_i[DATA_WIDTH-1 -: 8];
  assign pix16 = 16'(pix_data_i);

  // Register the sync levels so edges can be detected one cycle later.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      hsync_q <= hsync_i;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame FSM next-state logic; disabling capture always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cfg_en_i) state_nxt = ST_WAIT_SOF;
        else          state_nxt = ST_IDLE;
      end
      ST_WAIT_SOF: begin
        if (!cfg_en_i)                state_nxt = ST_IDLE;
        else if (sof && skip_cnt == 4'd0) state_nxt = ST_CAPTURE;
        else if (sof)                 state_nxt = ST_SKIP;
        else                          state_nxt = ST_WAIT_SOF;
      end
      ST_CAPTURE: begin
        if (!cfg_en_i) state_nxt = ST_IDLE;
        else if (eof)  state_nxt = ST_FLUSH;
        else           state_nxt = ST_CAPTURE;
      end
      ST_SKIP: begin
        if (!cfg_en_i) state_nxt = ST_IDLE;
        else if (eof)  state_nxt = ST_WAIT_SOF;
        else           state_nxt = ST_SKIP;
      end
      ST_FLUSH: begin
        if (!cfg_en_i) state_nxt = ST_IDLE;
        else           state_nxt = ST_WAIT_SOF;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decimation counter: reloaded after each captured frame, counted down per skipped frame.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      skip_cnt <= 4'd0;
    end else if (state == ST_IDLE) begin
      skip_cnt <= 4'd0;
    end else if (state == ST_FLUSH && cfg_en_i) begin
      skip_cnt <= cfg_frame_skip_i;
    end else if (state == ST_WAIT_SOF && cfg_en_i && sof && skip_cnt != 4'd0) begin
      skip_cnt <= skip_cnt - 4'd1;
    end else begin
      skip_cnt <= skip_cnt;
    end
  end

  // Saturating x/y coordinate counters; x is the pixel index within the current line.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      x_cnt <= {CNT_WIDTH{1'b0}};
      y_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      if (sof || eol) begin
        x_cnt <= {CNT_WIDTH{1'b0}};
      end else if (pix_valid_i && hsync_i && x_cnt != {CNT_WIDTH{1'b1}}) begin
        x_cnt <= x_cnt + CNT_WIDTH'(1);
      end else begin
        x_cnt <= x_cnt;
      end
      if (sof) begin
        y_cnt <= {CNT_WIDTH{1'b0}};
      end else if (eol && y_cnt != {CNT_WIDTH{1'b1}}) begin
        y_cnt <= y_cnt + CNT_WIDTH'(1);
      end else begin
        y_cnt <= y_cnt;
      end
    end
  end

  // Snapshot mode and window at start of frame so mid-frame writes cannot tear a frame.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mode_q    <= 1'b0;
      win_en_q  <= 1'b0;
      x_start_q <= {CNT_WIDTH{1'b0}};
      x_end_q   <= {CNT_WIDTH{1'b0}};
      y_start_q <= {CNT_WIDTH{1'b0}};
      y_end_q   <= {CNT_WIDTH{1'b0}};
    end else if (sof) begin
      mode_q    <= cfg_mode_i;
      win_en_q  <= cfg_win_en_i;
      x_start_q <= cfg_x_start_i;
      x_end_q   <= cfg_x_end_i;
      y_start_q <= cfg_y_start_i;
      y_end_q   <= cfg_y_end_i;
    end else begin
      mode_q    <= mode_q;
      win_en_q  <= win_en_q;
      x_start_q <= x_start_q;
      x_end_q   <= x_end_q;
      y_start_q <= y_start_q;
      y_end_q   <= y_end_q;
    end
  end

  assign in_win = ~win_en_q |
                  ((x_cnt >= x_start_q) & (x_cnt <= x_end_q) &
                   (y_cnt >= y_start_q) & (y_cnt <= y_end_q));

  assign accept    = (state == ST_CAPTURE) & cfg_en_i & pix_valid_i & hsync_i & in_win;
  assign last_lane = mode_q ? LANE_W'(LANES16 - 1) : LANE_W'(LANES8 - 1);

  // Insert the incoming pixel into the current lane for both pixel sizes.
  always_comb begin
    pack8_nxt  = pack;
    pack16_nxt = pack;
    for (int i = 0; i < LANES8; i++) begin
      if (lane == LANE_W'(i)) pack8_nxt[i*8 +: 8] = pix8;
      else                    pack8_nxt[i*8 +: 8] = pack[i*8 +: 8];
    end
    for (int i = 0; i < LANES16; i++) begin
      if (lane == LANE_W'(i)) pack16_nxt[i*16 +: 16] = pix16;
      else                    pack16_nxt[i*16 +: 16] = pack[i*16 +: 16];
    end
    if (mode_q) pack_nxt = pack16_nxt;
    else        pack_nxt = pack8_nxt;
  end

  // Word push: a full word as soon as its last lane fills, or the partial word at FLUSH.
  always_comb begin
    push_req  = 1'b0;
    push_word = pack;
    if (accept && lane == last_lane) begin
      push_req  = 1'b1;
      push_word = pack_nxt;
    end else if (state == ST_FLUSH && cfg_en_i && lane != {LANE_W{1'b0}}) begin
      push_req  = 1'b1;
      push_word = pack;
    end else begin
      push_req  = 1'b0;
      push_word = pack;
    end
  end

  // Pack register; cleared outside CAPTURE so partial words never survive a frame and
  // unused upper lanes of a flushed word read as zero.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pack <= {OUT_WIDTH{1'b0}};
      lane <= {LANE_W{1'b0}};
    end else if (state != ST_CAPTURE || !cfg_en_i) begin
      pack <= {OUT_WIDTH{1'b0}};
      lane <= {LANE_W{1'b0}};
    end else if (accept && lane == last_lane) begin
      pack <= {OUT_WIDTH{1'b0}};
      lane <= {LANE_W{1'b0}};
    end else if (accept) begin
      pack <= pack_nxt;
      lane <= lane + LANE_W'(1);
    end else begin
      pack <= pack;
      lane <= lane;
    end
  end

  assign empty   = (count == {(PTR_W+1){1'b0}});
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop     = ~empty & ready_i;
  assign push_ok = push_req & (~full | pop);

  // FIFO storage; data is only observable through valid entries.
  always_ff @(posedge clk_i) begin
    if (push_ok && !cfg_clr_i) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers, occupancy and sticky overflow; cfg_clr_i flushes and discards any push.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr   <= {PTR_W{1'b0}};
      rd_ptr   <= {PTR_W{1'b0}};
      count    <= {(PTR_W+1){1'b0}};
      overflow <= 1'b0;
    end else if (cfg_clr_i) begin
      wr_ptr   <= {PTR_W{1'b0}};
      rd_ptr   <= {PTR_W{1'b0}};
      count    <= {(PTR_W+1){1'b0}};
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      else         wr_ptr <= wr_ptr;
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      else     rd_ptr <= rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
      else                      overflow <= overflow;
    end
  end

  assign data_o      = empty ? {OUT_WIDTH{1'b0}} : mem[rd_ptr];
  assign valid_o     = ~empty;
  assign overflow_o  = overflow;
  assign busy_o      = (state != ST_IDLE);
  assign frame_evt_o = (state == ST_FLUSH) & cfg_en_i;

endmodule

// File: tb/tb_udma_cpi_pixel_packer.sv
// Directed self-checking bench for udma_cpi_pixel_packer (default parameters).
module tb_udma_cpi_pixel_packer;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        cfg_en_i;
  logic        cfg_mode_i;
  logic [3:0]  cfg_frame_skip_i;
  logic        cfg_win_en_i;
  logic [15:0] cfg_x_start_i;
  logic [15:0] cfg_x_end_i;
  logic [15:0] cfg_y_start_i;
  logic [15:0] cfg_y_end_i;
  logic        cfg_clr_i;
  logic        pix_valid_i;
  logic [9:0]  pix_data_i;
  logic        hsync_i;
  logic        vsync_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        frame_evt_o;
  logic        overflow_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int evt_cnt = 0;
  int e0;
  logic [31:0] got [$];
  logic [9:0]  pix_tab [0:31];

  always #5 clk = ~clk;

  udma_cpi_pixel_packer #(
    .DATA_WIDTH(10), .OUT_WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_mode_i(cfg_mode_i),
    .cfg_frame_skip_i(cfg_frame_skip_i), .cfg_win_en_i(cfg_win_en_i),
    .cfg_x_start_i(cfg_x_start_i), .cfg_x_end_i(cfg_x_end_i),
    .cfg_y_start_i(cfg_y_start_i), .cfg_y_end_i(cfg_y_end_i),
    .cfg_clr_i(cfg_clr_i), .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_evt_o(frame_evt_o), .overflow_o(overflow_o),
    .busy_o(busy_o)
  );

  // Record popped words and frame events mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (valid_o && ready_i) got.push_back(data_o);
    if (frame_evt_o) evt_cnt++;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One frame: lines x ppl pixels taken from pix_tab; returns one cycle after the EOF edge.
  task automatic send_frame(input int lines, input int ppl);
    int idx;
    idx = 0;
    vsync_i = 1'b1;
    tick(2);
    for (int l = 0; l < lines; l++) begin
      hsync_i = 1'b1;
      tick(1);
      for (int p = 0; p < ppl; p++) begin
        pix_valid_i = 1'b1;
        pix_data_i  = pix_tab[idx];
        idx++;
        tick(1);
      end
      pix_valid_i = 1'b0;
      hsync_i     = 1'b0;
      tick(1);
    end
    vsync_i = 1'b0;
    tick(1);
  endtask

  initial begin
    rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_mode_i = 1'b0; cfg_frame_skip_i = 4'd0;
    cfg_win_en_i = 1'b0; cfg_x_start_i = 16'd0; cfg_x_end_i = 16'd0;
    cfg_y_start_i = 16'd0; cfg_y_end_i = 16'd0; cfg_clr_i = 1'b0;
    pix_valid_i = 1'b0; pix_data_i = 10'd0; hsync_i = 1'b0; vsync_i = 1'b0;
    ready_i = 1'b1;
    tick(3);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ovf", {31'd0, overflow_o}, 32'd0);
    check("rst_evt", {31'd0, frame_evt_o}, 32'd0);

    // Basic mode 0 frame, 2 lines x 4 pixels
    rstn_i = 1'b1;
    cfg_en_i = 1'b1;
    tick(2);
    check("en_busy", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 32; i++) pix_tab[i] = 10'((i + 1) * 4);
    got.delete();
    e0 = evt_cnt;
    send_frame(2, 4);
    check("basic_evt_flush", {31'd0, frame_evt_o}, 32'd1);
    tick(1);
    check("basic_evt_after", {31'd0, frame_evt_o}, 32'd0);
    tick(3);
    check("basic_nwords", got.size(), 32'd2);
    check("basic_w0", got[0], 32'h04030201);
    check("basic_w1", got[1], 32'h08070605);
    check("basic_nevt", evt_cnt - e0, 32'd1);

    // Mode 1 with zero-padded flush
    cfg_mode_i = 1'b1;
    pix_tab[0] = 10'h3FF; pix_tab[1] = 10'h001; pix_tab[2] = 10'h155;
    got.delete();
    send_frame(1, 3);
    check("m1_evt_flush", {31'd0, frame_evt_o}, 32'd1);
    tick(3);
    check("m1_nwords", got.size(), 32'd2);
    check("m1_w0", got[0], 32'h000103FF);
    check("m1_w1", got[1], 32'h00000155);

    // Window x 1..2, y 1..1 on a 4x3 frame
    cfg_mode_i = 1'b0;
    cfg_win_en_i = 1'b1;
    cfg_x_start_i = 16'd1; cfg_x_end_i = 16'd2;
    cfg_y_start_i = 16'd1; cfg_y_end_i = 16'd1;
    for (int i = 0; i < 32; i++) pix_tab[i] = 10'((i + 1) * 4);
    got.delete();
    send_frame(3, 4);
    tick(3);
    check("win_nwords", got.size(), 32'd1);
    check("win_w0", got[0], 32'h00000706);

    // Window start > end accepts nothing but still ends the frame
    cfg_x_start_i = 16'd3; cfg_x_end_i = 16'd1;
    got.delete();
    e0 = evt_cnt;
    send_frame(3, 4);
    tick(3);
    check("winbad_nwords", got.size(), 32'd0);
    check("winbad_nevt", evt_cnt - e0, 32'd1);

    // Frame skip 2 over 6 frames: frames 0 and 3 captured
    cfg_win_en_i = 1'b0;
    cfg_frame_skip_i = 4'd2;
    got.delete();
    e0 = evt_cnt;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4; i++) pix_tab[i] = 10'((f * 4 + i + 1) * 4);
      send_frame(1, 4);
      tick(3);
    end
    check("skip_nevt", evt_cnt - e0, 32'd2);
    check("skip_nwords", got.size(), 32'd2);
    check("skip_w0", got[0], 32'h04030201);
    check("skip_w1", got[1], 32'h100F0E0D);
    cfg_frame_skip_i = 4'd0;

    // Overflow: 6 words into a 4-deep FIFO with ready low
    ready_i = 1'b0;
    for (int i = 0; i < 32; i++) pix_tab[i] = 10'((i + 1) * 4);
    got.delete();
    send_frame(6, 4);
    tick(2);
    check("ovf_flag", {31'd0, overflow_o}, 32'd1);
    check("ovf_valid", {31'd0, valid_o}, 32'd1);
    check("ovf_head", data_o, 32'h04030201);
    ready_i = 1'b1;
    tick(6);
    ready_i = 1'b0;
    check("ovf_nwords", got.size(), 32'd4);
    check("ovf_w0", got[0], 32'h04030201);
    check("ovf_w1", got[1], 32'h08070605);
    check("ovf_w2", got[2], 32'h0C0B0A09);
    check("ovf_w3", got[3], 32'h100F0E0D);
    check("ovf_empty", {31'd0, valid_o}, 32'd0);
    check("ovf_sticky", {31'd0, overflow_o}, 32'd1);
    cfg_clr_i = 1'b1;
    tick(1);
    cfg_clr_i = 1'b0;
    check("clr_ovf", {31'd0, overflow_o}, 32'd0);

    // Capture disabled mid-line: partial word lost, no frame event
    ready_i = 1'b1;
    got.delete();
    e0 = evt_cnt;
    vsync_i = 1'b1;
    tick(2);
    hsync_i = 1'b1;
    tick(1);
    for (int p = 0; p < 2; p++) begin
      pix_valid_i = 1'b1;
      pix_data_i  = 10'((p + 1) * 4);
      tick(1);
    end
    pix_valid_i = 1'b0;
    cfg_en_i = 1'b0;
    tick(1);
    check("dis_busy", {31'd0, busy_o}, 32'd0);
    hsync_i = 1'b0;
    tick(1);
    vsync_i = 1'b0;
    tick(4);
    check("dis_nevt", evt_cnt - e0, 32'd0);
    check("dis_nwords", got.size(), 32'd0);
    cfg_en_i = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) pix_tab[i] = 10'((i + 17) * 4);
    send_frame(1, 4);
    tick(3);
    check("reen_nwords", got.size(), 32'd1);
    check("reen_w0", got[0], 32'h14131211);

    // Reset mid-frame with FIFO full and overflow set
    ready_i = 1'b0;
    vsync_i = 1'b1;
    tick(2);
    hsync_i = 1'b1;
    tick(1);
    for (int p = 0; p < 22; p++) begin
      pix_valid_i = 1'b1;
      pix_data_i  = 10'((p + 1) * 4);
      tick(1);
    end
    pix_valid_i = 1'b0;
    check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    check("pre_rst_ovf", {31'd0, overflow_o}, 32'd1);
    rstn_i = 1'b0;
    tick(1);
    check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    check("mid_rst_data", data_o, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow_o}, 32'd0);
    check("mid_rst_evt", {31'd0, frame_evt_o}, 32'd0);
    hsync_i = 1'b0;
    vsync_i = 1'b0;
    rstn_i = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
